// File: rtl/mem_bus_responder.sv
// Memory-bus responder with a word-organised internal array.
// Each accepted request waits WAIT_CYCLES, then spends one ACCESS cycle
// and issues a one-cycle response. Illegal requests are answered
// immediately with rsp_err.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | ready for a request (req_ready = 1)
//   ST_WAIT  | wait-state countdown for a legal request
//   ST_ACCESS| one cycle; at its ending edge store commits / load registers
//   ST_RESP  | response strobe (rsp_valid = 1)
module mem_bus_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic          write_q;
  logic [1:0]    size_q;
  logic [1:0]    lane_q;
  logic [IW-1:0] idx_q;
  logic [31:0]   wdata_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic        accept;
  logic        req_bad;
  logic [31:0] word_addr;
  logic [31:0] rd_word;
  logic [31:0] rd_shift;
  logic [31:0] load_data;
  logic [3:0]  st_be;
  logic [31:0] st_data;

  assign accept    = req_valid && (state_q == ST_IDLE);
  assign word_addr = {2'b00, req_addr[31:2]};

  // Legality of the request presented on the bus this cycle.
  always_comb begin
    req_bad = 1'b0;
    if (req_size == 2'd3)                              req_bad = 1'b1;
    if (req_size == 2'd1 && req_addr[0])               req_bad = 1'b1;
    if (req_size == 2'd2 && req_addr[1:0] != 2'b00)    req_bad = 1'b1;
    if (word_addr >= 32'(DEPTH_WORDS))                 req_bad = 1'b1;
  end

  // Load path: shift the addressed lane down and zero-extend.
  always_comb begin
    rd_word   = mem_q[idx_q];
    rd_shift  = rd_word >> {lane_q, 3'b000};
    load_data = rd_word;
    case (size_q)
      2'd0:    load_data = {24'h0, rd_shift[7:0]};
      2'd1:    load_data = {16'h0, rd_shift[15:0]};
      default: load_data = rd_word;
    endcase
  end

  // Store path: byte enables and lane-aligned write data.
  always_comb begin
    st_data = wdata_q << {lane_q, 3'b000};
    case (size_q)
      2'd0:    st_be = 4'b0001 << lane_q;
      2'd1:    st_be = 4'b0011 << lane_q;
      default: st_be = 4'b1111;
    endcase
  end

  // State register and registered response fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= 4'd0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state logic; response fields hold outside the completing edge.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_bad) begin
            state_d     = ST_RESP;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else if (WAIT_CYCLES == 0) begin
            state_d = ST_ACCESS;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q <= 4'd1) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        state_d     = ST_RESP;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = write_q ? 32'h0 : load_data;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture at acceptance; later bus changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= req_write;
      size_q  <= req_size;
      lane_q  <= req_addr[1:0];
      idx_q   <= req_addr[IW+1:2];
      wdata_q <= req_wdata;
    end
  end

  // Array write at the end of ACCESS; reset on that edge aborts the store.
  always_ff @(posedge clk) begin
    if (!rst && state_q == ST_ACCESS && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem_q[idx_q][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: one instance with WAIT_CYCLES=2 and one with
// WAIT_CYCLES=0, driven one at a time and compared against a byte-array model.
module tb_mem_bus_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  int          sel;

  logic rv2, rv0;
  assign rv2 = req_valid && (sel == 0);
  assign rv0 = req_valid && (sel == 1);

  logic        rdy2, val2, err2, rdy0, val0, err0;
  logic [31:0] rd2, rd0;

  mem_bus_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(rv2), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(rdy2), .rsp_valid(val2), .rsp_rdata(rd2), .rsp_err(err2));

  mem_bus_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(rv0), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(rdy0), .rsp_valid(val0), .rsp_rdata(rd0), .rsp_err(err0));

  logic        rdy, val, err;
  logic [31:0] rd;
  assign rdy = (sel == 0) ? rdy2 : rdy0;
  assign val = (sel == 0) ? val2 : val0;
  assign err = (sel == 0) ? err2 : err0;
  assign rd  = (sel == 0) ? rd2  : rd0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Byte-addressed model memory, one per instance.
  logic [7:0] mdl [0:1][0:1023];

  function automatic int wcyc();
    return (sel == 0) ? 2 : 0;
  endfunction

  function automatic bit model_err(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd3) return 1'b1;
    if (size == 2'd1 && (addr % 2) != 0) return 1'b1;
    if (size == 2'd2 && (addr % 4) != 0) return 1'b1;
    if ((addr / 4) >= 256) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_exec(input logic w, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] er, output logic ee);
    int nb;
    er = 32'h0;
    ee = model_err(size, addr);
    if (!ee) begin
      nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      for (int i = 0; i < nb; i++) begin
        if (w) mdl[sel][int'(addr) + i] = wdata[8*i +: 8];
        else   er[8*i +: 8] = mdl[sel][int'(addr) + i];
      end
    end
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 50 && !rdy; i++) @(negedge clk);
    check({tag, ".ready_timeout"}, {31'b0, rdy}, 32'd1);
  endtask

  // Issue one request, follow it cycle by cycle to its response.
  task automatic run_req(input logic w, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input string tag);
    logic [31:0] er;
    logic        ee;
    int          exp_k;
    model_exec(w, size, addr, wdata, er, ee);
    wait_ready(tag);
    req_valid = 1'b1; req_write = w; req_size = size; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom); req_size = 2'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    exp_k = ee ? 0 : wcyc() + 1;
    for (int k = 0; k <= exp_k + 1; k++) begin
      if (k > 0) @(negedge clk);
      check({tag, ".rsp_valid"}, {31'b0, val}, (k == exp_k) ? 32'd1 : 32'd0);
      check({tag, ".req_ready"}, {31'b0, rdy}, (k > exp_k) ? 32'd1 : 32'd0);
      if (k >= exp_k) begin
        check({tag, ".rsp_rdata"}, rd, er);
        check({tag, ".rsp_err"}, {31'b0, err}, {31'b0, ee});
      end
    end
  endtask

  // Store that is killed by a reset pulse sampled kr edges after acceptance.
  task automatic abort_req(input logic [31:0] addr, input logic [31:0] wdata, input int kr,
                           input string tag);
    wait_ready(tag);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < kr; k++) begin
      check({tag, ".pre_rst_valid"}, {31'b0, val}, 32'd0);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check({tag, ".rst_ready"}, {31'b0, rdy}, 32'd1);
    check({tag, ".rst_valid"}, {31'b0, val}, 32'd0);
    check({tag, ".rst_err"}, {31'b0, err}, 32'd0);
    check({tag, ".rst_rdata"}, rd, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check({tag, ".no_rsp"}, {31'b0, val}, 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        w;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] er;
    logic        ee;
    int          n_acc, last_acc;
    logic        prev_val;

    sel = 0; rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_size = 2'd0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset.ready2", {31'b0, rdy2}, 32'd1);
    check("reset.valid2", {31'b0, val2}, 32'd0);
    check("reset.err2",   {31'b0, err2}, 32'd0);
    check("reset.rdata2", rd2, 32'h0);
    check("reset.ready0", {31'b0, rdy0}, 32'd1);
    check("reset.valid0", {31'b0, val0}, 32'd0);
    check("reset.err0",   {31'b0, err0}, 32'd0);
    check("reset.rdata0", rd0, 32'h0);

    for (int s = 0; s < 2; s++) begin
      sel = s;
      @(negedge clk);
      for (int i = 0; i < 16; i++)
        if (i != 4) run_req(1'b1, 2'd2, 32'(i * 4), $urandom, "init");

      run_req(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, "sw_10");
      run_req(1'b0, 2'd2, 32'h10, 32'h0,        "lw_10");
      run_req(1'b1, 2'd0, 32'h11, 32'h000000AA, "sb_11");
      run_req(1'b0, 2'd2, 32'h10, 32'h0,        "lw_10_after_sb");
      run_req(1'b0, 2'd0, 32'h13, 32'h0,        "lb_13");
      run_req(1'b0, 2'd1, 32'h12, 32'h0,        "lh_12");
      run_req(1'b0, 2'd2, 32'h12, 32'h0,        "lw_misaligned");
      run_req(1'b1, 2'd1, 32'h11, 32'h12345678, "sh_misaligned");
      run_req(1'b0, 2'd3, 32'h10, 32'h0,        "size3");
      run_req(1'b0, 2'd2, 32'h10, 32'h0,        "lw_10_after_err");
      run_req(1'b1, 2'd2, 32'h400, 32'hCAFEF00D, "sw_out_of_range");
      run_req(1'b0, 2'd2, 32'h0,  32'h0,        "lw_0");
      run_req(1'b1, 2'd2, 32'h20, 32'h11111111, "sw_20");
      abort_req(32'h20, 32'h22222222, 0, "abort_early");
      run_req(1'b0, 2'd2, 32'h20, 32'h0,        "lw_20_a");
      abort_req(32'h20, 32'h33333333, wcyc(), "abort_access");
      run_req(1'b0, 2'd2, 32'h20, 32'h0,        "lw_20_b");

      for (int n = 0; n < 120; n++) begin
        w  = 1'($urandom_range(0, 1));
        sz = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 7))
          0:       a = $urandom;
          1:       a = 32'h3F0 + 32'($urandom_range(0, 31));
          default: a = 32'($urandom_range(0, 63));
        endcase
        if (a >= 32'd64 && a < 32'd1024) w = 1'b1;
        run_req(w, sz, a, $urandom, "rand");
      end
    end

    // Zero-wait instance with req_valid held: accept every third cycle.
    sel = 1;
    @(negedge clk);
    wait_ready("stream");
    model_exec(1'b1, 2'd2, 32'h30, 32'hA5A55A5A, er, ee);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2;
    req_addr = 32'h30; req_wdata = 32'hA5A55A5A;
    n_acc = 0; last_acc = -1; prev_val = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (rdy) begin
        if (last_acc >= 0) check("stream.gap", 32'(c - last_acc), 32'd3);
        last_acc = c;
        n_acc++;
      end
      check("stream.no_back_to_back", {31'b0, prev_val & val}, 32'd0);
      prev_val = val;
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("stream.accept_count", 32'(n_acc), 32'd7);
    run_req(1'b0, 2'd2, 32'h30, 32'h0, "stream.readback");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
